alu_writeback_buffer: RTL and testbench

- Stage directly downstream of the ALU bitwise units (OR/AND/XOR/NOT).
- Captures each 16-bit ALU result and its destination register index into a small in-order FIFO.
- Drains the FIFO to the register-file write port under a valid/ready handshake.
- Maintains zero/negative status flags from the results actually written back, so an ALU result is never lost while the register-file port is busy.

---
 rtl/alu_writeback_buffer.sv | 111 +++++++++++
 tb/tb_alu_writeback_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_buffer.sv
// In-order writeback buffer between the ALU bitwise units and the register-file write port.
// Optional zero-latency bypass when empty: define WB_BYPASS_EN.
module alu_writeback_buffer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic [ADDR_W-1:0]        in_dest,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [WIDTH-1:0]         wb_data,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic                     zero_flag,
  output logic                     neg_flag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic   empty, full, push, pop, wb_fire;
  entry_t in_entry, head;

  assign in_entry = '{addr: in_dest, data: in_result};
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  // in_ready depends on occupancy only, never on wb_ready.
  assign in_ready = !full;

`ifdef WB_BYPASS_EN
  logic bypass;
  // An empty buffer forwards the incoming result straight to the write port.
  assign bypass   = empty && in_valid;
  assign wb_valid = !empty || in_valid;
  assign head     = !empty ? mem_q[rd_ptr_q] : (bypass ? in_entry : '0);
  assign push     = in_valid && in_ready && !(bypass && wb_ready);
  assign pop      = !empty && wb_ready;
`else
  assign wb_valid = !empty;
  assign head     = empty ? '0 : mem_q[rd_ptr_q];
  assign push     = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready;
`endif

  assign wb_fire   = wb_valid && wb_ready;
  assign wb_data   = head.data;
  assign wb_addr   = head.addr;
  assign zero_flag = zero_q;
  assign neg_flag  = neg_q;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Flags track what actually reached the register file, bypassed or buffered.
    if (wb_fire) begin
      zero_d = (head.data == '0);
      neg_d  = head.data[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  // Storage needs no reset: the output is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

endmodule

// File: tb/tb_alu_writeback_buffer.sv
// Directed bench for alu_writeback_buffer: expected writes queue up as stimulus is issued,
// a negedge monitor pops and compares on every write handshake.
module tb_alu_writeback_buffer;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_result;
  logic [ADDR_W-1:0] in_dest;
  logic              wb_valid;
  logic              wb_ready;
  logic [WIDTH-1:0]  wb_data;
  logic [ADDR_W-1:0] wb_addr;
  logic              zero_flag;
  logic              neg_flag;
  logic [2:0]        count;

  logic [ADDR_W+WIDTH-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  alu_writeback_buffer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_dest(in_dest),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr),
    .zero_flag(zero_flag), .neg_flag(neg_flag), .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL wb_unexpected: got addr %0d data 0x%0h with nothing expected", wb_addr, wb_data);
      end else begin
        check("wb_write", {13'd0, wb_addr, wb_data}, {13'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [WIDTH-1:0] d, input logic [ADDR_W-1:0] a);
    exp_q.push_back({a, d});
    in_valid  = 1'b1;
    in_result = d;
    in_dest   = a;
    next_cycle();
    in_valid  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_dest = '0; wb_ready = 1'b0;
    #12 reset = 1'b0;
    next_cycle();

    // reset state
    check("rst_count", 32'(count), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_flags", {30'd0, zero_flag, neg_flag}, 32'd0);

    // T1: single result, then write it back
    push_one(16'h00F0, 3'd3);
    check("t1_wb_valid", 32'(wb_valid), 32'd1);
    check("t1_head", {13'd0, wb_addr, wb_data}, {13'd0, 3'd3, 16'h00F0});
    wb_ready = 1'b1;
    next_cycle();
    wb_ready = 1'b0;
    check("t1_count", 32'(count), 32'd0);
    check("t1_flags", {30'd0, zero_flag, neg_flag}, 32'd0);

    // T2: two results held, then drained in order with flag updates
    push_one(16'h0000, 3'd1);
    push_one(16'h8001, 3'd2);
    check("t2_count", 32'(count), 32'd2);
    next_cycle();
    check("t2_head_stable", {13'd0, wb_addr, wb_data}, {13'd0, 3'd1, 16'h0000});
    wb_ready = 1'b1;
    next_cycle();
    check("t2_flags_pop1", {30'd0, zero_flag, neg_flag}, 32'b10);
    check("t2_count_pop1", 32'(count), 32'd1);
    next_cycle();
    check("t2_flags_pop2", {30'd0, zero_flag, neg_flag}, 32'b01);
    check("t2_count_pop2", 32'(count), 32'd0);
    wb_ready = 1'b0;

    // T3: fill, reject while full, pop on full cycle admits no push
    push_one(16'h1111, 3'd0);
    push_one(16'h2222, 3'd1);
    push_one(16'h3333, 3'd2);
    push_one(16'h4444, 3'd3);
    check("t3_full_count", 32'(count), 32'd4);
    check("t3_full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_result = 16'h5555; in_dest = 3'd5;
    next_cycle();
    check("t3_rejected_count", 32'(count), 32'd4);
    check("t3_head_after_reject", 32'(wb_data), 32'h1111);
    wb_ready = 1'b1;
    next_cycle();
    check("t3_pop_on_full_count", 32'(count), 32'd3);
    check("t3_in_ready_rises", 32'(in_ready), 32'd1);
    exp_q.push_back({3'd5, 16'h5555});
    next_cycle();
    in_valid = 1'b0;
    check("t3_push_pop_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) next_cycle();
    check("t3_drained", 32'(count), 32'd0);

    // T4: streaming 10 results with wb_ready held high
    for (int i = 0; i < 10; i++) begin
      logic [WIDTH-1:0] d;
      d = (i == 9) ? 16'h8421 : 16'h0101 * 16'(i + 1);
      exp_q.push_back({3'(i), d});
      in_valid = 1'b1; in_result = d; in_dest = 3'(i);
      next_cycle();
`ifdef WB_BYPASS_EN
      check("t4_stream_count", 32'(count), 32'd0);
`else
      check("t4_stream_count", 32'(count), 32'd1);
`endif
    end
    in_valid = 1'b0;
    next_cycle();
    check("t4_final_count", 32'(count), 32'd0);
    check("t4_flags", {30'd0, zero_flag, neg_flag}, 32'b01);
    wb_ready = 1'b0;

    // T5: asynchronous reset with three entries buffered
    push_one(16'h0A0A, 3'd4);
    push_one(16'h0B0B, 3'd5);
    push_one(16'h0C0C, 3'd6);
    check("t5_count_before", 32'(count), 32'd3);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check("t5_async_wb_valid", 32'(wb_valid), 32'd0);
    check("t5_async_count", 32'(count), 32'd0);
    check("t5_async_flags", {30'd0, zero_flag, neg_flag}, 32'd0);
    #4 reset = 1'b0;
    next_cycle();
    check("t5_in_ready_after", 32'(in_ready), 32'd1);
    push_one(16'h0BAD, 3'd6);
    push_one(16'h0C0D, 3'd7);
    wb_ready = 1'b1;
    next_cycle();
    next_cycle();
    check("t5_drained", 32'(count), 32'd0);

    // T6: latency from empty with wb_ready high
    in_valid = 1'b1; in_result = 16'hABCD; in_dest = 3'd5;
    exp_q.push_back({3'd5, 16'hABCD});
    #1;
`ifdef WB_BYPASS_EN
    check("t6_bypass_valid", 32'(wb_valid), 32'd1);
    check("t6_bypass_head", {13'd0, wb_addr, wb_data}, {13'd0, 3'd5, 16'hABCD});
    next_cycle();
    in_valid = 1'b0;
    check("t6_bypass_count", 32'(count), 32'd0);
`else
    check("t6_no_comb_path", 32'(wb_valid), 32'd0);
    next_cycle();
    in_valid = 1'b0;
    check("t6_latency_valid", 32'(wb_valid), 32'd1);
    check("t6_latency_head", {13'd0, wb_addr, wb_data}, {13'd0, 3'd5, 16'hABCD});
    check("t6_latency_count", 32'(count), 32'd1);
    next_cycle();
`endif
    check("t6_flags", {30'd0, zero_flag, neg_flag}, 32'b01);
    wb_ready = 1'b0;
    next_cycle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
